uart_tx_fifo_drain: RTL and testbench

//  Downstream consumer of the 8-bit sync FIFO. Pops one byte at a time via its read port and

---
 rtl/uart_tx_fifo_drain_pkg.sv | 28 ++
 rtl/uart_tx_fifo_drain_if.sv | 12 +
 rtl/uart_tx_fifo_drain_baud_tick.sv | 32 +++
 rtl/uart_tx_fifo_drain.sv | 131 +++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter: state encoding,
// data width and the rounded baud divisor calculation.
package uart_tx_fifo_drain_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] ST_IDLE_C  = 3'd0;
    localparam logic [2:0] ST_FETCH_C = 3'd1;
    localparam logic [2:0] ST_WAIT_C  = 3'd2;
    localparam logic [2:0] ST_START_C = 3'd3;
    localparam logic [2:0] ST_DATA_C  = 3'd4;
    localparam logic [2:0] ST_STOP_C  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = ST_IDLE_C,
        ST_FETCH = ST_FETCH_C,
        ST_WAIT  = ST_WAIT_C,
        ST_START = ST_START_C,
        ST_DATA  = ST_DATA_C,
        ST_STOP  = ST_STOP_C
    } state_e;

    // Nearest-integer clocks per baud period.
    function automatic int calc_divisor(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// FIFO read-port handshake between the synchronous FIFO (slave) and the
// UART drain logic (master).
interface uart_tx_fifo_drain_if;

    logic                                        rd_en;
    logic                                        empty;
    logic [uart_tx_fifo_drain_pkg::DATA_W-1:0]   rd_data;

    modport master (output rd_en, input empty, input rd_data);
    modport slave  (input rd_en, output empty, output rd_data);

endinterface

// File: rtl/uart_tx_fifo_drain_baud_tick.sv
// Free-running divisor counter with synchronous clear; tick is high while the
// count sits at divisor-1. Shared with the receive side.
module uart_baud_tick #(
    parameter  int pDivisor = 12,
    localparam int CNT_W    = $clog2(pDivisor)
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iClear,
    output logic             oTick,
    output logic [CNT_W-1:0] oCnt
);

    logic [CNT_W-1:0] cnt_q;

    // Count 0..divisor-1 and wrap; clear pins the count at zero.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (iClear) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (cnt_q == CNT_W'(pDivisor - 1)) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign oTick = (cnt_q == CNT_W'(pDivisor - 1));
    assign oCnt  = cnt_q;

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Pops bytes from the synchronous FIFO (1-cycle read latency) and serialises
// each one as 8N1/8N2 UART on oTx.
module uart_tx_fifo_drain
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int pClkFreq  = 12000000,
    parameter int pBaud     = 115200,
    parameter int pStopBits = 1
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic                 iEnable,
    uart_tx_fifo_drain_if.master fifo,
    output logic                 oTx,
    output logic                 oBusy,
    output logic                 oByteDone
);

    localparam int DIVISOR = calc_divisor(pClkFreq, pBaud);
    localparam int CNT_W   = $clog2(DIVISOR);

    state_e              state_q;
    logic                tx_q;
    logic                rd_en_q;
    logic                busy_q;
    logic                done_q;
    logic [2:0]          bit_cnt_q;
    logic                stop_cnt_q;
    logic [DATA_W-1:0]   shift_q;

    logic                tick_s;
    logic                baud_clr_s;
    logic                stop_last_s;
    logic [CNT_W-1:0]    baud_cnt_s;

    assign baud_clr_s  = (state_q == ST_IDLE) || (state_q == ST_FETCH) || (state_q == ST_WAIT);
    assign stop_last_s = (stop_cnt_q == 1'(pStopBits - 1));

    uart_baud_tick #(.pDivisor(DIVISOR)) u_baud (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iClear (baud_clr_s),
        .oTick  (tick_s),
        .oCnt   (baud_cnt_s)
    );

    // Frame sequencer; every output is a register updated alongside the state.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q    <= ST_IDLE;
            tx_q       <= 1'b1;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bit_cnt_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            shift_q    <= {DATA_W{1'b0}};
        end else begin
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    // Empty is only trusted here; the FIFO count has settled by now.
                    if (iEnable && !fifo.empty) begin
                        state_q <= ST_FETCH;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    shift_q <= fifo.rd_data;
                    tx_q    <= 1'b0;
                    state_q <= ST_START;
                end
                ST_START: begin
                    if (tick_s) begin
                        tx_q      <= shift_q[0];
                        bit_cnt_q <= 3'd0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        shift_q   <= shift_q >> 1;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            tx_q       <= 1'b1;
                            stop_cnt_q <= 1'b0;
                            state_q    <= ST_STOP;
                        end else begin
                            tx_q <= shift_q[1];
                        end
                    end
                end
                ST_STOP: begin
                    // Raised one count early so the pulse lands in the final stop clock.
                    if (stop_last_s && (baud_cnt_s == CNT_W'(DIVISOR - 2))) begin
                        done_q <= 1'b1;
                    end
                    if (tick_s) begin
                        if (stop_last_s) begin
                            state_q    <= ST_IDLE;
                            busy_q     <= 1'b0;
                            stop_cnt_q <= 1'b0;
                        end else begin
                            stop_cnt_q <= stop_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo.rd_en = rd_en_q;
    assign oTx        = tx_q;
    assign oBusy      = busy_q;
    assign oByteDone  = done_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench: FIFO model plus expected-byte scoreboard, frames decoded
// clock by clock from the serial line (divisor 12).
module tb_uart_tx_fifo_drain;

    logic clk;
    logic rst_n;
    logic en1;
    logic en2;
    logic tx1, busy1, done1;
    logic tx2, busy2, done2;
    logic sel;
    logic tx_m, busy_m, done_m;

    int checks;
    int errors;
    int rd1_cnt;
    int rd2_cnt;
    int underflow;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];

    uart_tx_fifo_drain_if f1();
    uart_tx_fifo_drain_if f2();

    uart_tx_fifo_drain #(.pClkFreq(12000000), .pBaud(1000000), .pStopBits(1)) dut (
        .iClk(clk), .iRst_n(rst_n), .iEnable(en1), .fifo(f1),
        .oTx(tx1), .oBusy(busy1), .oByteDone(done1)
    );

    uart_tx_fifo_drain #(.pClkFreq(12000000), .pBaud(1000000), .pStopBits(2)) dut2 (
        .iClk(clk), .iRst_n(rst_n), .iEnable(en2), .fifo(f2),
        .oTx(tx2), .oBusy(busy2), .oByteDone(done2)
    );

    assign tx_m   = sel ? tx2   : tx1;
    assign busy_m = sel ? busy2 : busy1;
    assign done_m = sel ? done2 : done1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model for the main instance: data appears the cycle after rd_en.
    always @(posedge clk) begin
        if (f1.rd_en === 1'b1) begin
            rd1_cnt++;
            if (fifo_q.size() == 0) begin
                underflow++;
            end else begin
                f1.rd_data <= fifo_q.pop_front();
                f1.empty   <= (fifo_q.size() == 0);
            end
        end
    end

    // Single-entry source for the two-stop-bit instance.
    always @(posedge clk) begin
        if (f2.rd_en === 1'b1) begin
            rd2_cnt++;
            if (f2.empty === 1'b1) underflow++;
            f2.empty <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(b);
        f1.empty = 1'b0;
    endtask

    // Waits for a start bit, then checks every clock of the frame.
    task automatic check_frame(input int stop_bits, input int drop_cycle, output int gap);
        logic [7:0] eb;
        logic       expl;
        logic       ok;
        int         nlev;
        int         done_n;
        int         done_pos;
        int         cyc;
        gap = 0;
        if (exp_q.size() == 0) begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
            eb = 8'h00;
        end else begin
            eb = exp_q.pop_front();
        end
        for (int w = 0; w < 2000; w++) begin
            @(negedge clk);
            if (tx_m === 1'b0) break;
            gap++;
        end
        chk($sformatf("start_seen_%02h", eb), 32'(tx_m), 32'd0);
        if (tx_m !== 1'b0) return;
        nlev     = 9 + stop_bits;
        done_n   = 0;
        done_pos = -1;
        for (int l = 0; l < nlev; l++) begin
            expl = (l == 0) ? 1'b0 : ((l <= 8) ? eb[l-1] : 1'b1);
            ok   = 1'b1;
            for (int c = 0; c < 12; c++) begin
                cyc = l * 12 + c;
                if (cyc > 0) @(negedge clk);
                if (cyc == drop_cycle) en1 = 1'b0;
                if (tx_m !== expl || busy_m !== 1'b1) ok = 1'b0;
                if (done_m === 1'b1) begin
                    done_n++;
                    done_pos = cyc;
                end
            end
            chk($sformatf("frame_%02h_level_%0d", eb, l), 32'(ok), 32'd1);
        end
        chk($sformatf("done_count_%02h", eb), 32'(done_n), 32'd1);
        chk($sformatf("done_pos_%02h", eb), 32'(done_pos), 32'(nlev * 12 - 1));
    endtask

    initial begin
        int  g;
        int  rd0;
        logic ok;
        checks     = 0;
        errors     = 0;
        rd1_cnt    = 0;
        rd2_cnt    = 0;
        underflow  = 0;
        sel        = 1'b0;
        en1        = 1'b1;
        en2        = 1'b1;
        f1.empty   = 1'b1;
        f1.rd_data = 8'h00;
        f2.empty   = 1'b1;
        f2.rd_data = 8'h00;
        rst_n      = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx1), 32'd1);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_rden", 32'(f1.rd_en), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        rst_n = 1'b1;

        // 1: empty FIFO, enabled -> stays idle
        ok = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (tx1 !== 1'b1 || busy1 !== 1'b0 || f1.rd_en !== 1'b0) ok = 1'b0;
        end
        chk("idle_500", 32'(ok), 32'd1);
        chk("idle_rden", 32'(rd1_cnt), 32'd0);

        // 2: single byte, latency and exact waveform
        rd0 = rd1_cnt;
        push_byte(8'hA5);
        check_frame(1, -1, g);
        chk("latency_a5", 32'(g), 32'd2);
        chk("rden_a5", 32'(rd1_cnt - rd0), 32'd1);

        // 3: back-to-back frames
        rd0 = rd1_cnt;
        push_byte(8'h00);
        push_byte(8'hFF);
        check_frame(1, -1, g);
        check_frame(1, -1, g);
        chk("gap_b2b", 32'(g), 32'd3);
        chk("rden_b2b", 32'(rd1_cnt - rd0), 32'd2);

        // 4: enable dropped during data bit 3
        rd0 = rd1_cnt;
        push_byte(8'h5A);
        push_byte(8'hC3);
        check_frame(1, 48, g);
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx1 !== 1'b1 || busy1 !== 1'b0) ok = 1'b0;
        end
        chk("disabled_idle", 32'(ok), 32'd1);
        chk("disabled_rden", 32'(rd1_cnt - rd0), 32'd1);
        en1 = 1'b1;
        check_frame(1, -1, g);
        chk("reenable_rden", 32'(rd1_cnt - rd0), 32'd2);

        // 5: asynchronous reset during data bit 5
        push_byte(8'h96);
        for (int w = 0; w < 100; w++) begin
            @(negedge clk);
            if (tx1 === 1'b0) break;
        end
        repeat (6 * 12 + 3) @(negedge clk);
        chk("pre_rst_busy", 32'(busy1), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_tx", 32'(tx1), 32'd1);
        chk("async_busy", 32'(busy1), 32'd0);
        chk("async_done", 32'(done1), 32'd0);
        void'(exp_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        push_byte(8'h21);
        check_frame(1, -1, g);
        chk("latency_after_rst", 32'(g), 32'd2);

        // 6: two stop bits
        sel        = 1'b1;
        f2.rd_data = 8'h3C;
        exp_q.push_back(8'h3C);
        f2.empty   = 1'b0;
        check_frame(2, -1, g);
        chk("rden_stop2", 32'(rd2_cnt), 32'd1);

        repeat (5) @(negedge clk);
        chk("underflow", 32'(underflow), 32'd0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
